// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the core/debug ALU arbiter.
// Port indices name the two requesters of this revision.
package alu_arbiter_pkg;

    typedef enum logic {
        IDLE,
        FULL
    } alu_arbiter_state_e;

    localparam int PORT_CORE  = 0;
    localparam int PORT_DEBUG = 1;
    localparam int NUM_REQ    = 2;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the ALU arbiter.
// master = requester side, slave = arbiter side.
`include "isa.svh"

interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int Width  = 32,
    parameter int NumReq = NUM_REQ
);

    logic [NumReq-1:0]                         req_valid;
    logic [NumReq-1:0]                         req_ready;
    logic [NumReq-1:0][Width-1:0]              req_a;
    logic [NumReq-1:0][Width-1:0]              req_b;
    logic [NumReq-1:0][`ISA__FUNCT3_WIDTH-1:0] req_op;
    logic [NumReq-1:0]                         req_mod;
    logic [NumReq-1:0]                         resp_valid;
    logic [NumReq-1:0]                         resp_ready;
    logic [Width-1:0]                          resp_c;

    modport master (
        output req_valid, req_a, req_b, req_op, req_mod, resp_ready,
        input  req_ready, resp_valid, resp_c
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_mod, resp_ready,
        output req_ready, resp_valid, resp_c
    );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU: funct3 decode with mod selecting SUB/SRA.
// Shift amount is the low log2(Width) bits of b.
`include "isa.svh"

module alu #(
    parameter int Width = 32
) (
    input  logic [Width-1:0]              a,
    input  logic [Width-1:0]              b,
    input  logic [`ISA__FUNCT3_WIDTH-1:0] op,
    input  logic                          mod,
    output logic [Width-1:0]              c
);

    localparam int ShW = $clog2(Width);

    logic [ShW-1:0]          sh;
    logic signed [Width-1:0] sra;

    assign sh  = b[ShW-1:0];
    assign sra = $signed(a) >>> sh;

    always_comb begin
        c = '0;
        case (op)
            `ISA__F3_ADD:  c = mod ? a - b : a + b;
            `ISA__F3_SLL:  c = a << sh;
            `ISA__F3_SLT:  c = {{(Width-1){1'b0}}, $signed(a) < $signed(b)};
            `ISA__F3_SLTU: c = {{(Width-1){1'b0}}, a < b};
            `ISA__F3_XOR:  c = a ^ b;
            `ISA__F3_SR:   c = mod ? $unsigned(sra) : a >> sh;
            `ISA__F3_OR:   c = a | b;
            `ISA__F3_AND:  c = a & b;
            default:       c = '0;
        endcase
    end

endmodule

// File: rtl/isa.svh
// Base-ISA funct3 encodings for the integer ALU.
// Shared by every block that decodes or carries an ALU opcode.
`ifndef ISA_SVH
`define ISA_SVH

`define ISA__FUNCT3_WIDTH 3

`define ISA__F3_ADD  3'b000
`define ISA__F3_SLL  3'b001
`define ISA__F3_SLT  3'b010
`define ISA__F3_SLTU 3'b011
`define ISA__F3_XOR  3'b100
`define ISA__F3_SR   3'b101
`define ISA__F3_OR   3'b110
`define ISA__F3_AND  3'b111

`endif

// File: rtl/alu_arbiter.sv
// One-slot arbiter sharing a single ALU between core and debug requesters.
// Define ALU_ARBITER_RR_EN for round-robin; otherwise port 0 has fixed priority.
`include "isa.svh"

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int Width  = 32,
    parameter int NumReq = NUM_REQ
) (
    input logic         clk,
    input logic         rst,
    alu_arbiter_if.slave bus
);

    localparam int IdxW = $clog2(NumReq);
    localparam int F3W  = `ISA__FUNCT3_WIDTH;

    alu_arbiter_state_e state_q;
    logic [Width-1:0]   a_q;
    logic [Width-1:0]   b_q;
    logic [F3W-1:0]     op_q;
    logic               mod_q;
    logic [IdxW-1:0]    owner_q;

    logic [IdxW-1:0]    g;
    logic               free;
    logic               accept;
    logic [NumReq-1:0]  ready;
    logic [NumReq-1:0]  rvalid;
    logic [Width-1:0]   c;

`ifdef ALU_ARBITER_RR_EN
    logic [IdxW-1:0] last_q;
    logic [IdxW-1:0] nxt;

    assign nxt = last_q + IdxW'(1);

    always_comb begin
        g = nxt;
        if (!bus.req_valid[nxt]) g = nxt + IdxW'(1);
    end
`else
    always_comb begin
        g = IdxW'(PORT_DEBUG);
        if (bus.req_valid[PORT_CORE]) g = IdxW'(PORT_CORE);
    end
`endif

    assign free = (state_q == IDLE) || bus.resp_ready[owner_q];

    // Ready never depends on operand data, only valid/state/resp_ready.
    always_comb begin
        ready = '0;
        if (!rst && free && |bus.req_valid) ready[g] = 1'b1;
    end

    assign accept = |(bus.req_valid & ready);

    always_comb begin
        rvalid = '0;
        if (state_q == FULL) rvalid[owner_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= `ISA__F3_ADD;
            mod_q   <= 1'b0;
            owner_q <= IdxW'(PORT_CORE);
`ifdef ALU_ARBITER_RR_EN
            last_q  <= IdxW'(NumReq - 1);
`endif
        end else if (accept) begin
            state_q <= FULL;
            a_q     <= bus.req_a[g];
            b_q     <= bus.req_b[g];
            op_q    <= bus.req_op[g];
            mod_q   <= bus.req_mod[g];
            owner_q <= g;
`ifdef ALU_ARBITER_RR_EN
            last_q  <= g;
`endif
        end else if (state_q == FULL && bus.resp_ready[owner_q]) begin
            state_q <= IDLE;
        end
    end

    alu #(
        .Width(Width)
    ) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .mod(mod_q),
        .c  (c)
    );

    assign bus.req_ready  = ready;
    assign bus.resp_valid = rvalid;
    assign bus.resp_c     = c;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus random bench for alu_arbiter against a transaction-level model.
// Expectations follow ALU_ARBITER_RR_EN when it is defined.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam logic [2:0] F_ADD  = 3'd0;
    localparam logic [2:0] F_SLL  = 3'd1;
    localparam logic [2:0] F_SLT  = 3'd2;
    localparam logic [2:0] F_SLTU = 3'd3;
    localparam logic [2:0] F_XOR  = 3'd4;
    localparam logic [2:0] F_SR   = 3'd5;
    localparam logic [2:0] F_OR   = 3'd6;
    localparam logic [2:0] F_AND  = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_arbiter_if #(.Width(W), .NumReq(2)) bus ();

    alu_arbiter #(.Width(W), .NumReq(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: slot occupancy, owner, expected result, last granted port.
    bit          m_full;
    int          m_owner;
    logic [31:0] m_res;
    int          m_last;

    logic [1:0]  obs_ready;
    logic [1:0]  obs_rvalid;
    logic [31:0] obs_c;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(logic [2:0] op, logic mod,
                                            logic [31:0] a, logic [31:0] b);
        int sh;
        logic [31:0] r;
        sh = int'(b[4:0]);
        case (op)
            F_ADD:  return mod ? a - b : a + b;
            F_SLL:  return a << sh;
            F_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            F_SLTU: return (a < b) ? 32'd1 : 32'd0;
            F_XOR:  return a ^ b;
            F_SR: begin
                r = a >> sh;
                if (mod && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
                return r;
            end
            F_OR:   return a | b;
            F_AND:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int pick(logic [1:0] v);
`ifdef ALU_ARBITER_RR_EN
        int first;
        first = (m_last + 1) % 2;
        return v[first] ? first : 1 - first;
`else
        return v[0] ? 0 : 1;
`endif
    endfunction

    task automatic put(int p, logic v, logic [2:0] op, logic mod,
                       logic [31:0] a, logic [31:0] b);
        bus.req_valid[p] = v;
        bus.req_op[p]    = op;
        bus.req_mod[p]   = mod;
        bus.req_a[p]     = a;
        bus.req_b[p]     = b;
    endtask

    // Called just after a negedge with inputs set; returns after the posedge.
    task automatic step();
        logic [1:0] v;
        logic [1:0] exp_ready;
        logic [1:0] exp_rv;
        int g;
        bit free;
        #1;
        v = bus.req_valid;
        free = !m_full || bus.resp_ready[m_owner];
        g = pick(v);
        exp_ready = (v != 2'b00 && free) ? 2'(2'b01 << g) : 2'b00;
        exp_rv = m_full ? 2'(2'b01 << m_owner) : 2'b00;
        obs_ready  = bus.req_ready;
        obs_rvalid = bus.resp_valid;
        obs_c      = bus.resp_c;
        check("req_ready", 32'(obs_ready), 32'(exp_ready));
        check("resp_valid", 32'(obs_rvalid), 32'(exp_rv));
        if (m_full) check("resp_c", obs_c, m_res);
        @(posedge clk);
        if (exp_ready != 2'b00) begin
            m_full  = 1'b1;
            m_owner = g;
            m_res   = ref_alu(bus.req_op[g], bus.req_mod[g],
                              bus.req_a[g], bus.req_b[g]);
            m_last  = g;
        end else if (m_full && bus.resp_ready[m_owner]) begin
            m_full = 1'b0;
        end
    endtask

    initial begin
        logic [2:0]  s_op [4];
        logic [31:0] s_a  [4];
        logic [31:0] s_b  [4];
        logic [31:0] s_r  [4];
        logic [1:0]  exp2;

        s_op = '{F_SLT, F_SLTU, F_XOR, F_SLL};
        s_a  = '{32'hFFFF_FFFF, 32'd1, 32'hF0, 32'd1};
        s_b  = '{32'd1, 32'd2, 32'h0F, 32'd31};
        s_r  = '{32'd1, 32'd1, 32'hFF, 32'h8000_0000};

        m_full = 1'b0; m_owner = 0; m_res = '0; m_last = 1;
        bus.resp_ready = 2'b00;
        put(0, 1'b1, F_ADD, 1'b0, 32'd0, 32'd0);
        put(1, 1'b1, F_ADD, 1'b0, 32'd0, 32'd0);

        #3;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rvalid", 32'(bus.resp_valid), 32'd0);
        check("rst_c", bus.resp_c, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 2'b00;

        // Port 0 ADD 5+3
        put(0, 1'b1, F_ADD, 1'b0, 32'd5, 32'd3);
        bus.resp_ready = 2'b00;
        step();
        check("add_ready", 32'(obs_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b01;
        step();
        check("add_rvalid", 32'(obs_rvalid), 32'h1);
        check("add_c", obs_c, 32'd8);

        // Port 1 SUB 3-5, port 0 resp_ready toggles
        @(negedge clk);
        put(1, 1'b1, F_ADD, 1'b1, 32'd3, 32'd5);
        bus.resp_ready = 2'b00;
        step();
        check("sub_ready", 32'(obs_ready), 32'h2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid = 2'b00;
            bus.resp_ready = {1'b0, 1'(i)};
            step();
            check("sub_rvalid", 32'(obs_rvalid), 32'h2);
            check("sub_c", obs_c, 32'hFFFF_FFFE);
        end

        // Both ports valid, responses always accepted
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            put(0, 1'b1, F_ADD, 1'b0, 32'(i), 32'd1);
            put(1, 1'b1, F_ADD, 1'b0, 32'(i), 32'd2);
            bus.resp_ready = 2'b11;
            step();
`ifdef ALU_ARBITER_RR_EN
            exp2 = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp2 = 2'b01;
`endif
            check("both_grant", 32'(obs_ready), 32'(exp2));
        end

        // SRA under backpressure, port 1 waiting
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b11;
        step();
        @(negedge clk);
        put(0, 1'b1, F_SR, 1'b1, 32'h8000_0000, 32'd4);
        bus.resp_ready = 2'b00;
        step();
        check("sra_ready", 32'(obs_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid[0] = 1'b0;
            put(1, 1'b1, F_ADD, 1'b0, 32'd7, 32'd7);
            bus.resp_ready = 2'b00;
            step();
            check("sra_hold_ready", 32'(obs_ready), 32'h0);
            check("sra_c", obs_c, 32'hF800_0000);
        end
        @(negedge clk);
        bus.resp_ready = 2'b01;
        step();
        check("sra_release_ready", 32'(obs_ready), 32'h2);
        check("sra_last_c", obs_c, 32'hF800_0000);

        // Back-to-back stream on port 0
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b11;
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) put(0, 1'b1, s_op[k], 1'b0, s_a[k], s_b[k]);
            else bus.req_valid = 2'b00;
            bus.resp_ready = 2'b11;
            step();
            if (k < 4) check("stream_ready", 32'(obs_ready), 32'h1);
            if (k > 0) begin
                check("stream_rvalid", 32'(obs_rvalid), 32'h1);
                check("stream_c", obs_c, s_r[k-1]);
            end
        end

        // Asynchronous reset while FULL
        @(negedge clk);
        put(0, 1'b1, F_ADD, 1'b0, 32'h1234, 32'h1);
        bus.resp_ready = 2'b00;
        step();
        @(negedge clk);
        bus.req_valid = 2'b11;
        #2 rst = 1'b1;
        #1;
        check("arst_rvalid", 32'(bus.resp_valid), 32'd0);
        check("arst_c", bus.resp_c, 32'd0);
        check("arst_ready", 32'(bus.req_ready), 32'd0);
        m_full = 1'b0; m_owner = 0; m_last = 1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 2'b11;
        bus.resp_ready = 2'b11;
        step();
        check("post_rst_grant", 32'(obs_ready), 32'h1);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                put(p, 1'($urandom_range(0, 1)), 3'($urandom % 8),
                    1'($urandom % 2),
                    ($urandom % 4 == 0) ? 32'($urandom % 16) : 32'($urandom),
                    ($urandom % 4 == 0) ? 32'($urandom % 40) : 32'($urandom));
            end
            bus.resp_ready = 2'($urandom % 4);
            step();
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
